// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : Integer register file with two combinational read ports that
//             bypass same-cycle write-back, a registered debug read port,
//             write tracking (written mask, write counter) and a sticky flag
//             for attempted writes to the hardwired-zero register 0.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        rd_in,
   input  logic [DATA_W-1:0] rd_data_in,
   input  logic              reg_write_in,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [NREG-1:0]   written_mask,
   output logic [31:0]       wr_count,
   output logic              x0_write_seen
);

   // One past the highest implemented address, widened so 32 still fits.
   localparam logic [5:0] NREG_LIM = 6'(NREG);

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   mask_q;
   logic [31:0]       count_q;
   logic              x0_seen_q;
   logic [DATA_W-1:0] dbg_q;

   logic wr_accept;
   logic wr_x0;
   logic rs1_valid;
   logic rs2_valid;
   logic dbg_valid;
   logic rs1_hit;
   logic rs2_hit;

   // An address is readable when it is nonzero and names an implemented register.
   assign rs1_valid = (rs1_addr != 5'd0) && ({1'b0, rs1_addr} < NREG_LIM);
   assign rs2_valid = (rs2_addr != 5'd0) && ({1'b0, rs2_addr} < NREG_LIM);
   assign dbg_valid = (dbg_addr != 5'd0) && ({1'b0, dbg_addr} < NREG_LIM);

   // Writes to register 0 are never accepted; they only raise the sticky flag.
   assign wr_accept = reg_write_in && (rd_in != 5'd0) && ({1'b0, rd_in} < NREG_LIM);
   assign wr_x0     = reg_write_in && (rd_in == 5'd0);

   // Bypass is independent of reset so the read ports stay live while reset is low.
   assign rs1_hit = wr_accept && (rd_in == rs1_addr);
   assign rs2_hit = wr_accept && (rd_in == rs2_addr);

   // Register storage: cleared by reset, otherwise updated by accepted writes.
   // Entry 0 is only ever cleared; reads of address 0 never look at it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_accept) begin
         regs[rd_in] <= rd_data_in;
      end
   end

   // Read port 1: zero for address 0, write-back data on a same-cycle hit.
   always_comb begin
      rs1_data = '0;
      if (rs1_valid) begin
         rs1_data = rs1_hit ? rd_data_in : regs[rs1_addr];
      end
   end

   // Read port 2: same behaviour as read port 1.
   always_comb begin
      rs2_data = '0;
      if (rs2_valid) begin
         rs2_data = rs2_hit ? rd_data_in : regs[rs2_addr];
      end
   end

   // Debug port samples the stored value, so a same-cycle write is not visible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dbg_q <= '0;
      end else begin
         dbg_q <= dbg_valid ? regs[dbg_addr] : '0;
      end
   end

   // Written mask: bit set on each accepted write; bit 0 can never be set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q <= '0;
      end else if (wr_accept) begin
         mask_q[rd_in] <= 1'b1;
      end
   end

   // Accepted-write counter, free-running with natural wrap at 2^32.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (wr_accept) begin
         count_q <= count_q + 32'd1;
      end
   end

   // Sticky flag for any write attempt aimed at register 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         x0_seen_q <= 1'b0;
      end else if (wr_x0) begin
         x0_seen_q <= 1'b1;
      end
   end

   assign dbg_data      = dbg_q;
   assign written_mask  = mask_q;
   assign wr_count      = count_q;
   assign x0_write_seen = x0_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : Directed self-checking bench for register_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

   logic        clk;
   logic        reset;
   logic [4:0]  rd_in;
   logic [31:0] rd_data_in;
   logic        reg_write_in;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] written_mask;
   logic [31:0] wr_count;
   logic        x0_write_seen;

   int total;
   int bad;

   register_file #(.DATA_W(32), .NREG(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_in        (rd_in),
      .rd_data_in   (rd_data_in),
      .reg_write_in (reg_write_in),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .written_mask (written_mask),
      .wr_count     (wr_count),
      .x0_write_seen(x0_write_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are then changed away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b0;
      rd_in        = 5'd0;
      rd_data_in   = 32'd0;
      reg_write_in = 1'b0;
      rs1_addr     = 5'd0;
      rs2_addr     = 5'd0;
      dbg_addr     = 5'd0;

      // Reset held for two edges.
      tick();
      tick();
      check("rst_mask", 64'(written_mask), 64'h0);
      check("rst_count", 64'(wr_count), 64'h0);
      check("rst_x0", 64'(x0_write_seen), 64'h0);
      check("rst_dbg", 64'(dbg_data), 64'h0);

      // Release and read every address on both ports.
      reset = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         #1;
         check("rst_rs1", 64'(rs1_data), 64'h0);
         check("rst_rs2", 64'(rs2_data), 64'h0);
      end

      // Write x5 = DEADBEEF, read back the following cycle.
      rd_in        = 5'd5;
      rd_data_in   = 32'hDEAD_BEEF;
      reg_write_in = 1'b1;
      tick();
      reg_write_in = 1'b0;
      rd_data_in   = 'x;
      rs1_addr     = 5'd5;
      #1;
      check("wr_x5_rs1", 64'(rs1_data), 64'hDEAD_BEEF);
      check("wr_x5_mask", 64'(written_mask), 64'h0000_0020);
      check("wr_x5_count", 64'(wr_count), 64'h1);

      // Preload x7 = 0x11.
      rd_in        = 5'd7;
      rd_data_in   = 32'h11;
      reg_write_in = 1'b1;
      tick();
      check("x7_count", 64'(wr_count), 64'h2);
      check("x7_mask", 64'(written_mask), 64'h0000_00A0);

      // Same-cycle bypass of x7 = 0x22 on both ports; debug samples x7 too.
      rd_data_in = 32'h22;
      rs1_addr   = 5'd7;
      rs2_addr   = 5'd7;
      dbg_addr   = 5'd7;
      #1;
      check("byp_rs1", 64'(rs1_data), 64'h22);
      check("byp_rs2", 64'(rs2_data), 64'h22);
      tick();
      reg_write_in = 1'b0;
      rd_data_in   = 'x;
      #1;
      check("byp_dbg_old", 64'(dbg_data), 64'h11);
      check("byp_rs1_stored", 64'(rs1_data), 64'h22);
      check("byp_count", 64'(wr_count), 64'h3);
      tick();
      check("dbg_new", 64'(dbg_data), 64'h22);

      // Write attempt to x0.
      rd_in        = 5'd0;
      rd_data_in   = 32'hFFFF_FFFF;
      reg_write_in = 1'b1;
      rs1_addr     = 5'd0;
      rs2_addr     = 5'd5;
      dbg_addr     = 5'd0;
      #1;
      check("x0_rs1_same", 64'(rs1_data), 64'h0);
      check("x0_seen_before", 64'(x0_write_seen), 64'h0);
      tick();
      reg_write_in = 1'b0;
      rd_data_in   = 'x;
      #1;
      check("x0_rs1", 64'(rs1_data), 64'h0);
      check("x0_rs2_x5", 64'(rs2_data), 64'hDEAD_BEEF);
      check("x0_seen", 64'(x0_write_seen), 64'h1);
      check("x0_count", 64'(wr_count), 64'h3);
      check("x0_mask", 64'(written_mask), 64'h0000_00A0);
      check("x0_dbg", 64'(dbg_data), 64'h0);

      // Idle cycles with garbage data and no enable change nothing.
      tick();
      tick();
      check("idle_count", 64'(wr_count), 64'h3);
      check("idle_seen", 64'(x0_write_seen), 64'h1);

      // Counter wrap: preload the counter, then one write to x1.
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      #1;
      check("wrap_preload", 64'(wr_count), 64'hFFFF_FFFF);
      rd_in        = 5'd1;
      rd_data_in   = 32'h1234;
      reg_write_in = 1'b1;
      tick();
      reg_write_in = 1'b0;
      rs1_addr     = 5'd1;
      #1;
      check("wrap_count", 64'(wr_count), 64'h0);
      check("wrap_mask", 64'(written_mask), 64'h0000_00A2);
      check("wrap_x1", 64'(rs1_data), 64'h1234);

      // Reset coincident with a write to x3: bypass stays live, write dropped.
      reset        = 1'b0;
      rd_in        = 5'd3;
      rd_data_in   = 32'h55;
      reg_write_in = 1'b1;
      rs1_addr     = 5'd3;
      rs2_addr     = 5'd5;
      #1;
      check("rstw_bypass", 64'(rs1_data), 64'h55);
      tick();
      reset        = 1'b1;
      reg_write_in = 1'b0;
      #1;
      check("rstw_x3", 64'(rs1_data), 64'h0);
      check("rstw_x5", 64'(rs2_data), 64'h0);
      check("rstw_count", 64'(wr_count), 64'h0);
      check("rstw_mask", 64'(written_mask), 64'h0);
      check("rstw_seen", 64'(x0_write_seen), 64'h0);

      // Top register after reset.
      rd_in        = 5'd31;
      rd_data_in   = 32'hA5A5_5A5A;
      reg_write_in = 1'b1;
      tick();
      reg_write_in = 1'b0;
      rs2_addr     = 5'd31;
      dbg_addr     = 5'd31;
      #1;
      check("x31_rs2", 64'(rs2_data), 64'hA5A5_5A5A);
      check("x31_mask", 64'(written_mask), 64'h8000_0000);
      check("x31_count", 64'(wr_count), 64'h1);
      tick();
      check("x31_dbg", 64'(dbg_data), 64'hA5A5_5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
